// File: rtl/spi_rx_packer.sv
// spi_rx_packer: assembles MSB-first words from a qualified serial bit stream and buffers them in a FWFT FIFO.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-low reset, synchronous release
//   i_bits_out     serial data bit from the SPI master
//   i_bit_valid    i_bits_out carries a new bit this cycle
//   i_frame_start  start of a new frame; discards any partial word
//   o_word_data    head-of-FIFO word, 0 while o_word_valid is low
//   o_word_valid   FIFO not empty
//   i_word_ready   consumer accepts the head word
//   o_level        number of stored words (0..DEPTH)
//   o_overflow     sticky flag: a completed word was dropped
//   i_clear_ovf    clears o_overflow (a same-cycle drop wins)
module spi_rx_packer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_bits_out,
    input  logic                       i_bit_valid,
    input  logic                       i_frame_start,
    output logic [DATA_W-1:0]          o_word_data,
    output logic                       o_word_valid,
    input  logic                       i_word_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    input  logic                       i_clear_ovf
);
    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t            r_state, w_state_n;
    logic [BW-1:0]     r_bcnt, w_bcnt_n;
    // Only DATA_W-1 bits need storing: the final bit comes straight from the input.
    logic [DATA_W-2:0] r_sh, w_sh_n;
    logic [DATA_W-1:0] w_word;
    logic              w_done;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [LW-1:0]     r_level;
    logic              r_ovf;
    logic              w_valid, w_full, w_pop, w_push, w_drop;

    assign w_word = {r_sh, i_bits_out};

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_n;
            r_bcnt  <= w_bcnt_n;
            r_sh    <= w_sh_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_bcnt_n  = r_bcnt;
        w_sh_n    = r_sh;
        w_done    = 1'b0;
        if (i_bit_valid && i_frame_start) begin
            // A bit arriving with frame_start is the MSB of a fresh word.
            w_state_n = S_SHIFT;
            w_bcnt_n  = BW'(1);
            w_sh_n    = (DATA_W-1)'(i_bits_out);
        end else if (i_bit_valid) begin
            w_sh_n = w_word[DATA_W-2:0];
            if (r_state == S_SHIFT && r_bcnt == BW'(DATA_W-1)) begin
                w_done    = 1'b1;
                w_state_n = S_IDLE;
                w_bcnt_n  = '0;
            end else begin
                w_state_n = S_SHIFT;
                w_bcnt_n  = r_bcnt + BW'(1);
            end
        end else if (i_frame_start) begin
            w_state_n = S_IDLE;
            w_bcnt_n  = '0;
            w_sh_n    = '0;
        end
    end

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = w_valid && i_word_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push  = w_done && (!w_full || w_pop);
    assign w_drop  = w_done && w_full && !w_pop;

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_push && !w_pop) r_level <= r_level + LW'(1);
            else if (w_pop && !w_push) r_level <= r_level - LW'(1);
            if (w_drop) r_ovf <= 1'b1;
            else if (i_clear_ovf) r_ovf <= 1'b0;
        end
    end

    assign o_word_valid = w_valid;
    assign o_word_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level      = r_level;
    assign o_overflow   = r_ovf;
endmodule
